// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame RAM between display line fetch and host writes.
// A fetch streams one line (H_ACT pixels) out of RAM. One cycle in every
// WR_SLOT is offered to a pending host write. Between fetches, host writes
// are granted immediately.
module vga_fb_arbiter #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int WR_SLOT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [8:0]  line_num,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_idx,
  output logic        fetch_busy,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int          SW        = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(WR_SLOT - 1);
  localparam logic [9:0]  H_LIM     = 10'(H_ACT);
  localparam logic [8:0]  V_LIM     = 9'(V_ACT);
  localparam logic [18:0] H_MUL     = 19'(H_ACT);
  localparam logic [18:0] FB_SIZE   = 19'(H_ACT * V_ACT);

  logic [1:0]    state;
  logic [18:0]   base;
  logic [18:0]   base_nxt;
  logic [9:0]    rd_cnt;
  logic [SW-1:0] slot;
  logic          wr_ok;
  logic          go_fetch;
  logic          do_wr;
  logic          do_rd;
  logic          rd_out;

  // A write may only be granted when the previous one is not being acked
  // this very cycle; the host still holds wr_req while it sees the ack.
  assign wr_ok  = wr_req & ~wr_ack;
  // A read is on the RAM bus this cycle; its data is captured at the next edge.
  assign rd_out = mem_en & ~mem_we;

  // Line base address: line_num * H_ACT as a sum of shifted copies.
  always_comb begin
    base_nxt = '0;
    for (int i = 0; i < 19; i++) begin
      if (H_MUL[i]) base_nxt = base_nxt + ({10'b0, line_num} << i);
    end
  end

  // Decide which access (if any) the FSM issues this cycle.
  always_comb begin
    go_fetch = 1'b0;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    case (state)
      S_IDLE: begin
        go_fetch = line_start && (line_num < V_LIM);
        do_wr    = !go_fetch && wr_ok;
      end
      S_FETCH: begin
        if (rd_cnt != H_LIM) begin
          do_wr = (slot == SLOT_LAST) && wr_ok;
          do_rd = !do_wr;
        end
      end
      default: ;
    endcase
  end

  // FSM, RAM port registers, pixel stream and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base       <= '0;
      rd_cnt     <= '0;
      slot       <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_idx    <= '0;
      fetch_busy <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      pix_valid <= rd_out;
      // rd_cnt has already moved past the read now on the bus
      if (rd_out) begin
        pix_data <= mem_rdata;
        pix_idx  <= rd_cnt - 10'd1;
      end

      if (do_wr) begin
        wr_ack <= 1'b1;
        // out-of-frame writes are acked but never reach the RAM
        if (wr_addr < FB_SIZE) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
      end else if (do_rd) begin
        mem_en   <= 1'b1;
        mem_addr <= base + {9'b0, rd_cnt};
        rd_cnt   <= rd_cnt + 10'd1;
      end

      case (state)
        S_IDLE: begin
          if (go_fetch) begin
            base       <= base_nxt;
            rd_cnt     <= '0;
            slot       <= '0;
            state      <= S_FETCH;
            fetch_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          // all reads issued: the last one is on the bus now
          if (rd_cnt == H_LIM) state <= S_DRAIN;
          else slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end
        S_DRAIN: begin
          // last pixel is presented this cycle
          state      <= S_IDLE;
          fetch_busy <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          fetch_busy <= 1'b0;
        end
      endcase

      if (line_start && state != S_IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a combinational RAM read model.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [8:0]  line_num;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [9:0]  pix_idx;
  logic        fetch_busy;
  logic        overrun;

  int n_chk = 0;
  int n_bad = 0;

  int m_busy, m_nrd, m_nwr, m_npx, m_err, m_first_wr, m_first_rd;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_idx(pix_idx), .fetch_busy(fetch_busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM content as a function of address
  function automatic logic [7:0] rd_model(input int a);
    return 8'(a) + 8'(a >> 3);
  endfunction
  assign mem_rdata = mem_addr[7:0] + mem_addr[10:3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Follows one fetch from its first busy cycle (C1) until fetch_busy drops.
  task automatic watch(input int base, input bit hostw, input int inj);
    bit prev_rd, done, first_seen;
    int last_wr;
    m_busy = 0; m_nrd = 0; m_nwr = 0; m_npx = 0; m_err = 0;
    m_first_wr = -1; m_first_rd = 0;
    prev_rd = 0; done = 0; first_seen = 0; last_wr = -10;
    for (int c = 1; c < 1200 && !done; c++) begin
      if (fetch_busy) m_busy++;
      if (pix_valid !== prev_rd) m_err++;
      if (pix_valid) begin
        if (pix_idx !== 10'(m_npx) || pix_data !== rd_model(base + m_npx)) m_err++;
        m_npx++;
      end
      prev_rd = mem_en && !mem_we;
      if (mem_en && !first_seen) begin
        first_seen = 1;
        m_first_rd = int'(!mem_we);
      end
      if (mem_en && !mem_we) begin
        if (mem_addr !== 19'(base + m_nrd)) m_err++;
        m_nrd++;
      end
      if (wr_ack) begin
        m_nwr++;
        if (m_first_wr < 0) m_first_wr = c;
        if (!(mem_en && mem_we) || mem_addr !== wr_addr || mem_wdata !== wr_data ||
            c - last_wr < 2 || c % 4 != 1) m_err++;
        last_wr = c;
        wr_addr = wr_addr + 19'd1;
        wr_data = wr_data + 8'd7;
      end
      if (!hostw && wr_ack) m_err++;
      if (c == inj) begin
        line_start = 1'b1;
        line_num   = 9'd5;
      end else begin
        line_start = 1'b0;
      end
      if (!fetch_busy && c > 1) done = 1;
      else tick();
    end
    wr_req     = 1'b0;
    line_start = 1'b0;
    chk("fetch_end", 32'(done), 32'd1);
  endtask

  initial begin
    int pv;
    rst_n = 1'b0; line_start = 1'b0; line_num = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;

    // host write in IDLE, then no grant while acking
    wr_req = 1'b1; wr_addr = 19'd100; wr_data = 8'hA5;
    tick();
    chk("wr_en", 32'(mem_en), 1);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 100);
    chk("wr_data", 32'(mem_wdata), 32'hA5);
    chk("wr_ack", 32'(wr_ack), 1);
    tick();
    chk("wr_gap_ack", 32'(wr_ack), 0);
    chk("wr_gap_en", 32'(mem_en), 0);
    wr_req = 1'b0;
    tick();

    // out-of-frame write: acked, dropped, address held
    wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 8'h11;
    tick();
    chk("oob_ack", 32'(wr_ack), 1);
    chk("oob_en", 32'(mem_en), 0);
    chk("oob_hold_addr", 32'(mem_addr), 100);
    wr_req = 1'b0;
    tick();

    // out-of-range line ignored
    line_start = 1'b1; line_num = 9'd480;
    tick();
    line_start = 1'b0;
    chk("l480_busy", 32'(fetch_busy), 0);
    chk("l480_en", 32'(mem_en), 0);
    tick();
    chk("l480_busy2", 32'(fetch_busy), 0);
    chk("l480_overrun", 32'(overrun), 0);

    // plain fetch of line 2
    line_start = 1'b1; line_num = 9'd2;
    tick();
    line_start = 1'b0;
    watch(1280, 0, -1);
    chk("f2_busy", 32'(m_busy), 642);
    chk("f2_reads", 32'(m_nrd), 640);
    chk("f2_pix", 32'(m_npx), 640);
    chk("f2_writes", 32'(m_nwr), 0);
    chk("f2_err", 32'(m_err), 0);
    chk("f2_overrun", 32'(overrun), 0);

    // line 0 with continuous host writes starting in the same cycle
    tick();
    wr_req = 1'b1; wr_addr = 19'd1000; wr_data = 8'd1;
    line_start = 1'b1; line_num = 9'd0;
    tick();
    line_start = 1'b0;
    watch(0, 1, -1);
    chk("f0w_busy", 32'(m_busy), 855);
    chk("f0w_reads", 32'(m_nrd), 640);
    chk("f0w_pix", 32'(m_npx), 640);
    chk("f0w_writes", 32'(m_nwr), 213);
    chk("f0w_first_wr", 32'(m_first_wr), 5);
    chk("f0w_first_rd", 32'(m_first_rd), 1);
    chk("f0w_err", 32'(m_err), 0);

    // line_start during fetch sets overrun, fetch unchanged
    tick();
    chk("ovr_before", 32'(overrun), 0);
    line_start = 1'b1; line_num = 9'd1;
    tick();
    line_start = 1'b0;
    watch(640, 0, 10);
    chk("ovr_busy", 32'(m_busy), 642);
    chk("ovr_reads", 32'(m_nrd), 640);
    chk("ovr_err", 32'(m_err), 0);
    chk("ovr_flag", 32'(overrun), 1);
    tick();
    chk("ovr_sticky", 32'(overrun), 1);

    // reset in the middle of a fetch
    line_start = 1'b1; line_num = 9'd3;
    tick();
    line_start = 1'b0;
    repeat (300) tick();
    chk("mid_busy", 32'(fetch_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_en", 32'(mem_en), 0);
    chk("mrst_we", 32'(mem_we), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_wdata", 32'(mem_wdata), 0);
    chk("mrst_pv", 32'(pix_valid), 0);
    chk("mrst_pdata", 32'(pix_data), 0);
    chk("mrst_pidx", 32'(pix_idx), 0);
    chk("mrst_busy", 32'(fetch_busy), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    pv = 0;
    repeat (3) begin
      tick();
      if (pix_valid) pv++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (pix_valid || fetch_busy || mem_en) pv++;
    end
    chk("mrst_quiet", 32'(pv), 0);
    line_start = 1'b1; line_num = 9'd0;
    tick();
    line_start = 1'b0;
    watch(0, 0, -1);
    chk("rf_busy", 32'(m_busy), 642);
    chk("rf_pix", 32'(m_npx), 640);
    chk("rf_err", 32'(m_err), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- WR_SLOT, 4, write-slot period in cycles during FETCH.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; the single clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- line_start, in, 1, one-cycle pulse requesting a fetch of one display line.
- line_num, in, 9, line index (0..V_ACT-1), sampled with line_start.
- wr_req, in, 1, host write request; held until wr_ack.
- wr_addr, in, 19, host pixel address.
- wr_data, in, 8, host pixel data.
- wr_ack, out, 1, one-cycle pulse; the write is committed this cycle.
- mem_en, out, 1, RAM access enable.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, 19, RAM address.
- mem_wdata, out, 8, RAM write data.
- mem_rdata, in, 8, RAM read data; valid one cycle after a read access.
- pix_valid, out, 1, pix_data/pix_idx valid for the line buffer.
- pix_data, out, 8, fetched pixel.
- pix_idx, out, 10, pixel column (0..H_ACT-1).
- fetch_busy, out, 1, high while state != IDLE.
- overrun, out, 1, sticky: line_start arrived while busy.

Function
REQ-003 The block SHALL share one single-port frame RAM between line fetch (display) and host writes.
REQ-004 All mem_*, wr_ack, pix_*, fetch_busy and overrun outputs SHALL be registered.
REQ-005 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-006 IDLE, line_start with line_num<V_ACT:
- latch base = line_num*H_ACT (19-bit, shift-add, no multiplier);
- clear read and slot counters;
- go to FETCH.
REQ-007 IDLE, line_start with line_num>=V_ACT: the pulse SHALL be ignored, with no state change and no overrun.
REQ-008 IDLE, wr_req high and wr_ack low: the write SHALL be granted, so next cycle mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
REQ-009 IDLE, line_start and wr_req in the same cycle: the fetch SHALL win and the write SHALL wait for a FETCH write slot.
REQ-010 FETCH slot counter: counts 0..WR_SLOT-1 and wraps, advancing every FETCH cycle.
REQ-011 FETCH, slot==WR_SLOT-1 with wr_req high and wr_ack low: that cycle SHALL carry the host write, and no read is issued.
REQ-012 All other FETCH cycles SHALL issue a read: mem_en=1, mem_we=0, mem_addr=base+rd_cnt, then rd_cnt increments.
REQ-013 pix_valid SHALL be high exactly one cycle after each read access, with pix_data=mem_rdata and pix_idx equal to that read's rd_cnt; indices SHALL be contiguous 0..H_ACT-1 in order.
REQ-014 FETCH SHALL go to DRAIN when the H_ACT-th read is issued; DRAIN SHALL last one cycle (last pix_valid) and then return to IDLE.
REQ-015 Worst-case fetch length SHALL be at most H_ACT + ceil(H_ACT/(WR_SLOT-1)) + 1 cycles, i.e. 855 for the defaults.
REQ-016 No write SHALL be granted in a cycle where wr_ack is high, so consecutive writes are at least 2 cycles apart.
REQ-017 A write with wr_addr >= H_ACT*V_ACT (307200) SHALL be acked with mem_en=0; the write is dropped.
REQ-018 line_start while in FETCH or DRAIN SHALL set overrun=1 and SHALL otherwise be ignored; overrun clears only on reset.
REQ-019 When no access is granted, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.

Reset
REQ-020 rst_n low SHALL immediately force:
- state=IDLE;
- all counters=0;
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
- wr_ack=0, pix_valid=0, pix_data=0, pix_idx=0;
- fetch_busy=0, overrun=0.
REQ-021 Reset during FETCH SHALL abort the fetch; no pix_valid SHALL occur after reset assertion until a new line_start.
REQ-022 After rst_n rises, the first clock edge SHALL evaluate IDLE inputs normally.

Verification
REQ-023 Fetch, no host traffic: line_start with line_num=2 -> 640 reads at addresses 1280..1919 on consecutive cycles; pix_idx 0..639 each one cycle after its read; fetch_busy high for 642 cycles.
REQ-024 Host write in IDLE: wr_req, wr_addr=100, wr_data=0xA5 -> next cycle mem_we=1, mem_addr=100, mem_wdata=0xA5, wr_ack=1; no grant in the following cycle.
REQ-025 Continuous wr_req through a fetch of line 0 -> writes only in slot-3 cycles, at least 2 cycles apart; reads total 640 and stay contiguous; fetch finishes within 855 cycles.
REQ-026 Simultaneous line_start(line_num=0) and wr_req in IDLE -> first access is a read of address 0; the write is acked in the first eligible slot.
REQ-027 Boundaries:
- line_start during FETCH -> overrun=1 and the fetch completes unchanged;
- line_num=480 -> ignored;
- wr_addr=307200 -> wr_ack=1 with mem_en=0.
REQ-028 rst_n low at rd_cnt=300 -> outputs go to their reset values immediately; no pix_valid until the next line_start, which restarts at pix_idx=0.
